// File: rtl/char_text_renderer.sv
// rtl/char_text_renderer.sv - renders one scaled line of glyph-memory characters over the VGA raster
module char_text_renderer #(
    parameter int NUM_CHARS  = 8,
    parameter int SCALE_LOG2 = 2,
    parameter int ORIGIN_X   = 16,
    parameter int ORIGIN_Y   = 16,
    localparam int AW        = $clog2(NUM_CHARS)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [9:0]    hpos,
    input  logic [9:0]    vpos,
    input  logic          de_in,
    input  logic [1:0]    sync_in,
    input  logic          txt_we,
    input  logic [AW-1:0] txt_addr,
    input  logic [5:0]    txt_data,
    output logic [1:0]    mem_x,
    output logic [2:0]    mem_y,
    input  logic [35:0]   mem_data,
    output logic          pixel_on,
    output logic          de_out,
    output logic [1:0]    sync_out
);

    localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);
    localparam logic [AW-1:0] CHR_MAX = AW'(NUM_CHARS - 1);
    localparam logic [9:0]    ORG_X   = 10'(ORIGIN_X);
    localparam logic [9:0]    ORG_Y   = 10'(ORIGIN_Y);
    localparam logic [5:0]    BLANK   = 6'd63;
    localparam logic [5:0]    NUM_GLYPHS = 6'd36;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] sub_cnt, sub_nx;
    logic [2:0]    col_cnt, col_nx;
    logic [AW-1:0] chr_cnt, chr_nx;

    logic          enter;
    logic          run;
    logic [SW-1:0] cur_sub;
    logic [2:0]    cur_col;
    logic [AW-1:0] cur_chr;
    logic [5:0]    cur_code;

    logic [9:0]    v_off;
    logic [9:0]    v_row;
    logic          inside_v;
    logic          hit;

    logic [5:0]    txt_buf [NUM_CHARS];

    logic [5:0]    code_r;
    logic          hit_r;
    logic          de_d1;
    logic [1:0]    sync_d1;

    // The entering cycle renders with zeroed counters, so select the effective position here.
    always_comb begin
        enter    = (state == S_IDLE) && de_in && (hpos == ORG_X);
        run      = enter || ((state == S_ACTIVE) && de_in);
        cur_sub  = enter ? '0 : sub_cnt;
        cur_col  = enter ? 3'd0 : col_cnt;
        cur_chr  = enter ? '0 : chr_cnt;
        cur_code = txt_buf[cur_chr];
    end

    always_comb begin
        state_nx = state;
        sub_nx   = sub_cnt;
        col_nx   = col_cnt;
        chr_nx   = chr_cnt;
        case (state)
            S_IDLE, S_ACTIVE: begin
                if (run) begin
                    state_nx = S_ACTIVE;
                    if (cur_sub == SUB_MAX) begin
                        sub_nx = '0;
                        if (cur_col == 3'd4) begin
                            col_nx = 3'd0;
                            chr_nx = cur_chr + AW'(1);
                            if (cur_chr == CHR_MAX) begin
                                state_nx = S_DONE;
                                chr_nx   = '0;
                            end
                        end else begin
                            col_nx = cur_col + 3'd1;
                        end
                    end else begin
                        sub_nx = cur_sub + SW'(1);
                    end
                end else begin
                    state_nx = S_IDLE;
                    sub_nx   = '0;
                    col_nx   = 3'd0;
                    chr_nx   = '0;
                end
            end
            S_DONE: begin
                if (!de_in) begin
                    state_nx = S_IDLE;
                    sub_nx   = '0;
                    col_nx   = 3'd0;
                    chr_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                sub_nx   = '0;
                col_nx   = 3'd0;
                chr_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sub_cnt <= '0;
            col_cnt <= 3'd0;
            chr_cnt <= '0;
        end else begin
            state   <= state_nx;
            sub_cnt <= sub_nx;
            col_cnt <= col_nx;
            chr_cnt <= chr_nx;
        end
    end

    always_comb begin
        v_off    = vpos - ORG_Y;
        v_row    = v_off >> SCALE_LOG2;
        inside_v = (vpos >= ORG_Y) && (v_row < 10'd5);
        hit      = run && inside_v && (cur_col < 3'd4) && (cur_code < NUM_GLYPHS);
    end

    // Reads above see the pre-write entry, so a same-edge write affects only later pixels.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                txt_buf[i] <= BLANK;
            end
        end else if (txt_we) begin
            txt_buf[txt_addr] <= txt_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            mem_x   <= 2'd0;
            mem_y   <= 3'd0;
            code_r  <= 6'd0;
            hit_r   <= 1'b0;
            de_d1   <= 1'b0;
            sync_d1 <= 2'd0;
        end else begin
            if (hit) begin
                mem_x <= cur_col[1:0];
                mem_y <= v_row[2:0];
            end
            code_r  <= cur_code;
            hit_r   <= hit;
            de_d1   <= de_in;
            sync_d1 <= sync_in;
        end
    end

    // hit_r guarantees code_r < 36, so the bit select stays in range whenever it matters.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            pixel_on <= 1'b0;
            de_out   <= 1'b0;
            sync_out <= 2'd0;
        end else begin
            pixel_on <= hit_r && mem_data[code_r];
            de_out   <= de_d1;
            sync_out <= sync_d1;
        end
    end

endmodule

// File: doc/char_text_renderer.md
Name: char_text_renderer

Overview:
- Read-side companion to the glyph memory array: scans the VGA raster and renders one line of up to NUM_CHARS characters at a fixed screen origin.
- Drives glyph-memory column/row addresses (mem_x, mem_y) and picks one bit of the 36-bit glyph-memory output per pixel.
- Holds its own small text buffer, writable from the control side. Output is a per-pixel on/off flag plus delayed DE/sync, aligned for the colour stage.

Parameters:
NUM_CHARS, 8, characters in the text line (power of 2, 2..16)
SCALE_LOG2, 2, each glyph pixel covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen pixels
ORIGIN_X, 16, hpos of leftmost rendered screen pixel
ORIGIN_Y, 16, vpos of top rendered screen pixel

Ports:
clock  input  1  system/pixel clock
rst_n  input  1  asynchronous active-low reset
hpos  input  10  current pixel column from VGA timing
vpos  input  10  current pixel row from VGA timing
de_in  input  1  display-enable for hpos/vpos
sync_in  input  2  {vsync,hsync} from VGA timing
txt_we  input  1  text buffer write strobe
txt_addr  input  log2(NUM_CHARS)  text buffer entry
txt_data  input  6  character code
mem_x  output  2  glyph column address to glyph memory
mem_y  output  3  glyph row address to glyph memory
mem_data  input  36  glyph memory bits, combinational function of mem_x/mem_y
pixel_on  output  1  foreground pixel
de_out  output  1  de_in delayed 2 cycles
sync_out  output  2  sync_in delayed 2 cycles

Behaviour:
- Reset (async, rst_n=0): all outputs 0. Text buffer entries = 63 (blank). Horizontal FSM = IDLE. All counters = 0.
- Character code k (0..35) selects mem_data[k]:
  - k=35 'A' ... k=10 'Z'
  - k=9 '0' ... k=0 '9'
  - k>=36 renders blank, with no mem_data access dependency.
- Glyph is 4 columns x 5 rows. Character cell is 5 glyph columns wide (column 4 = blank gap) and 5 rows tall.
- Horizontal FSM advances only on cycles with de_in=1; hpos must increment by 1 per such cycle.
  - IDLE -> ACTIVE when de_in=1 and hpos==ORIGIN_X. Sub-counter, glyph-column counter and char-index counter are all cleared.
  - ACTIVE: sub-counter counts 0..2^SCALE_LOG2-1.
    - On sub-counter wrap, glyph column advances 0..4.
    - On column wrap (4->0), char index advances.
    - On the last sub-pixel of column 4 of char NUM_CHARS-1 -> DONE.
  - DONE -> IDLE on de_in falling edge (end of line).
  - de_in=0 in ACTIVE (line ends early) -> IDLE; counters cleared.
- Vertical is combinational on vpos:
  - inside_v = (vpos>=ORIGIN_Y) and ((vpos-ORIGIN_Y)>>SCALE_LOG2) < 5.
  - glyph row = that quotient.
- Pipeline, latency 2 from hpos/vpos/de_in/sync_in:
  - Stage 1 (registered): mem_x = glyph column[1:0], mem_y = glyph row, code = buffer[char index], and a hit flag. Hit = ACTIVE (including the entering cycle) & inside_v & column<4 & code<36. When hit=0, mem_x/mem_y hold their previous value.
  - Stage 2 (registered): pixel_on = hit_r & mem_data[code_r]. de_out and sync_out are delayed to match.
  - pixel_on is never 1 when de_out=0.
- Text buffer write is synchronous on the clock edge with txt_we=1. A pixel sampled on that same edge uses the old value; pixels from the next cycle on use the new value. No write-protect during active video.
- Glyph-memory write muxing of x/y is handled above this block. While glyph writes are in progress, mem_x/mem_y from this block are don't-care and pixel_on is unspecified.
- Reset mid-frame: outputs drop to 0 immediately. After release, rendering resumes correctly from the next line whose hpos passes ORIGIN_X.

Test Plan:
- Reset: rst_n=0 mid-line -> pixel_on, de_out, sync_out, mem_x, mem_y = 0 within the same cycle. Buffer reads back as blank, so a full frame renders pixel_on=0 everywhere.
- Glyph 'A' at char0, SCALE_LOG2=0, ORIGIN=(16,16): write code 35 to entry 0, sweep the frame.
  - pixel_on at (16+c, 16+r) equals the 'A' glyph memory bit (c,r) for c<4, r<5.
  - Column 20 is 0.
  - Everything outside the text window is 0.
  - Latency is exactly 2 cycles vs de_in.
- Scaling, SCALE_LOG2=2: code 9 ('0') in entry 0 -> each glyph bit appears as a 4x4 block. Cell 1 starts at hpos ORIGIN_X+20.
- Boundaries: codes 36 and 63 -> blank cell. Last cell ends at hpos ORIGIN_X+NUM_CHARS*5*2^SCALE_LOG2-1; nothing rendered after it. Rows vpos=ORIGIN_Y+5*2^SCALE_LOG2 and beyond -> 0.
- Write during scan: txt_we on the cycle hpos enters char 2 -> that pixel uses the old code, the following pixel the new code.
- Early de_in drop inside ACTIVE -> FSM returns to IDLE, and the next line renders identically to the first.
